// File: rtl/reg2_arb_pkg.sv
// Shared types and constants for the reg2 write arbiter: FSM encoding, widths and
// the round-robin pointer advance.
package reg2_arb_pkg;

  localparam int unsigned REG_W = 3;
  localparam int unsigned NREQ  = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StCheck = 3'd2,
    StAck   = 3'd3,
    StClear = 3'd4
  } state_e;

  // Pointer moves to the requester just after the one that was served.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/reg2_arbiter_if.sv
// Requester / shared-register bundle of the reg2 arbiter. The master side drives
// requests and register readback, the slave side is the arbiter itself.
interface reg2_arbiter_if #(
  parameter int unsigned W    = 3,
  parameter int unsigned NREQ = 3
) ();

  logic [NREQ-1:0] req;
  logic [W-1:0]    d0;
  logic [W-1:0]    d1;
  logic [W-1:0]    d2;
  logic            clr;
  logic [W-1:0]    reg_q;

  logic [W-1:0]    reg_d;
  logic            reg_ena;
  logic            reg_rst;
  logic            reg_set;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic            err;
  logic            clr_done;
  logic            busy;

  modport master (
    output req, d0, d1, d2, clr, reg_q,
    input  reg_d, reg_ena, reg_rst, reg_set, gnt, ack, err, clr_done, busy
  );

  modport slave (
    input  req, d0, d1, d2, clr, reg_q,
    output reg_d, reg_ena, reg_rst, reg_set, gnt, ack, err, clr_done, busy
  );

endinterface

// File: rtl/reg2_arbiter_rr_arb3.sv
// Combinational three-way round-robin picker: the requester at ptr_i has highest
// priority, then ptr_i+1, then ptr_i+2 (mod 3).
module rr_arb3
  import reg2_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [1:0]      idx_o,
  output logic            any_o
);

  logic [1:0] base;
  logic [1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    base  = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = 2'((int'(base) + k) % int'(NREQ));
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg2_arbiter.sv
// Round-robin write arbiter/sequencer for one shared 3-bit reg2 register: grants a
// requester, writes its data, verifies the readback and acknowledges it.
module reg2_arbiter
  import reg2_arb_pkg::*;
#(
  parameter int unsigned W    = REG_W,
  parameter int unsigned NREQ = 3
) (
  input  logic          eck,
  input  logic          er,
  reg2_arbiter_if.slave bus_io
);

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      win_q;
  logic [W-1:0]    data_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic            ena_q;
  logic            rst_q;
  logic            clr_pend_q;
  logic            clr_done_q;
  logic            busy_q;

  logic [NREQ-1:0] arb_gnt;
  logic [1:0]      arb_idx;
  logic            arb_any;
  logic [W-1:0]    sel_data;
  logic            rdbk_mismatch;

  rr_arb3 u_rr_arb3 (
    .req_i (bus_io.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    sel_data = bus_io.d0;
    case (arb_idx)
      2'd1:    sel_data = bus_io.d1;
      2'd2:    sel_data = bus_io.d2;
      default: sel_data = bus_io.d0;
    endcase
  end

  always_comb begin
    rdbk_mismatch = (bus_io.reg_q != data_q);
  end

  // Every output is loaded on the same edge that enters the state it belongs to,
  // so nothing reaches the register pins combinationally from req.
  always_ff @(posedge eck) begin
    if (er) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      win_q      <= 2'd0;
      data_q     <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      ena_q      <= 1'b0;
      rst_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q      <= '0;
      err_q      <= 1'b0;
      ena_q      <= 1'b0;
      rst_q      <= 1'b0;
      clr_done_q <= 1'b0;

      // A clear seen mid-write is remembered; repeats merge into one.
      if (bus_io.clr && (state_q inside {StWrite, StCheck, StAck})) begin
        clr_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (clr_pend_q || bus_io.clr) begin
            state_q    <= StClear;
            rst_q      <= 1'b1;
            busy_q     <= 1'b1;
            clr_pend_q <= 1'b0;
          end else if (arb_any) begin
            state_q <= StWrite;
            win_q   <= arb_idx;
            gnt_q   <= arb_gnt;
            data_q  <= sel_data;
            ena_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StWrite: begin
          state_q <= StCheck;
        end
        StCheck: begin
          state_q <= StAck;
          ack_q   <= gnt_q;
          err_q   <= rdbk_mismatch;
        end
        StAck: begin
          state_q <= StIdle;
          ptr_q   <= rr_next(win_q);
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        StClear: begin
          state_q    <= StIdle;
          clr_done_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.reg_d    = data_q;
  assign bus_io.reg_ena  = ena_q;
  assign bus_io.reg_rst  = rst_q;
  assign bus_io.reg_set  = 1'b0;
  assign bus_io.gnt      = gnt_q;
  assign bus_io.ack      = ack_q;
  assign bus_io.err      = err_q;
  assign bus_io.clr_done = clr_done_q;
  assign bus_io.busy     = busy_q;

endmodule

// File: tb/tb_reg2_arbiter.sv
// Directed bench for reg2_arbiter with a behavioural reg2 looped back onto reg_q and
// a scoreboard of expected acknowledgements.
module tb_reg2_arbiter;

  typedef struct packed {
    logic [2:0] ack;
    logic       err;
    logic [2:0] data;
  } exp_t;

  logic       eck = 1'b0;
  logic       er;
  logic [2:0] sq;
  logic       force_zero;
  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  always #5 eck = ~eck;

  reg2_arbiter_if #(.W(3), .NREQ(3)) bus ();

  reg2_arbiter #(.W(3), .NREQ(3)) u_dut (
    .eck    (eck),
    .er     (er),
    .bus_io (bus)
  );

  // Shared register model; force_zero emulates a stuck readback.
  always @(posedge eck) begin
    if (er || bus.reg_rst)   sq <= 3'b000;
    else if (bus.reg_set)    sq <= 3'b111;
    else if (bus.reg_ena)    sq <= bus.reg_d;
  end
  assign bus.reg_q = force_zero ? 3'b000 : sq;

  task automatic step();
    @(posedge eck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    er = 1'b1;
    step();
    step();
    er = 1'b0;
  endtask

  // Steps until an ack appears (bounded), then checks it against the scoreboard.
  task automatic wait_ack(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == 3'b000 && n < exp_lat + 4);
    e = '0;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_ack"}, bus.ack, e.ack);
    chk({tag, "_err"}, bus.err, e.err);
    chk({tag, "_rdbk"}, bus.reg_q, e.data);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_c;
    exp_t e;

    er = 1'b1;
    force_zero = 1'b0;
    bus.req = 3'b000;
    bus.d0 = 3'b000;
    bus.d1 = 3'b000;
    bus.d2 = 3'b000;
    bus.clr = 1'b0;
    step();
    step();
    er = 1'b0;
    chk("rst_outputs", {bus.gnt, bus.ack, bus.err, bus.clr_done, bus.busy, bus.reg_ena,
                        bus.reg_rst, bus.reg_set, bus.reg_d}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {bus.gnt, bus.ack, bus.busy, bus.reg_ena, bus.reg_rst}, 32'h0);
    end

    // Single write from requester 0.
    bus.req = 3'b001;
    bus.d0 = 3'b101;
    e = '{ack: 3'b001, err: 1'b0, data: 3'b101};
    sb_q.push_back(e);
    step();
    chk("w1_ena", bus.reg_ena, 1);
    chk("w1_d", bus.reg_d, 3'b101);
    chk("w1_gnt", bus.gnt, 3'b001);
    chk("w1_busy", bus.busy, 1);
    step();
    chk("w1_chk_ena", bus.reg_ena, 0);
    chk("w1_chk_gnt", bus.gnt, 3'b001);
    wait_ack("w1", 1);
    bus.req = 3'b000;
    step();
    chk("w1_after", {bus.busy, bus.ack, bus.gnt}, 32'h0);
    chk("w1_hold", bus.reg_q, 3'b101);

    // Round-robin contention from a fresh pointer.
    do_reset();
    bus.req = 3'b111;
    bus.d0 = 3'd1;
    bus.d1 = 3'd2;
    bus.d2 = 3'd3;
    e = '{ack: 3'b001, err: 1'b0, data: 3'd1}; sb_q.push_back(e);
    e = '{ack: 3'b010, err: 1'b0, data: 3'd2}; sb_q.push_back(e);
    e = '{ack: 3'b100, err: 1'b0, data: 3'd3}; sb_q.push_back(e);
    e = '{ack: 3'b001, err: 1'b0, data: 3'd1}; sb_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr", (i == 0) ? 3 : 4);
    end
    bus.req = 3'b000;
    step();
    chk("rr_idle", bus.busy, 0);

    // Clear wins over a simultaneous request.
    chk("cp_pre", bus.reg_q, 3'd1);
    bus.req = 3'b010;
    bus.d1 = 3'b011;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("cp_rst", bus.reg_rst, 1);
    chk("cp_ena", bus.reg_ena, 0);
    chk("cp_gnt", bus.gnt, 3'b000);
    step();
    chk("cp_done", bus.clr_done, 1);
    chk("cp_zero", bus.reg_q, 3'b000);
    chk("cp_rst_off", bus.reg_rst, 0);
    e = '{ack: 3'b010, err: 1'b0, data: 3'b011};
    sb_q.push_back(e);
    step();
    chk("cp_wr_gnt", bus.gnt, 3'b010);
    chk("cp_wr_ena", bus.reg_ena, 1);
    chk("cp_done_off", bus.clr_done, 0);
    wait_ack("cp", 2);
    bus.req = 3'b000;
    step();

    // Clear held across WRITE and CHECK: write completes, then exactly one clear.
    bus.req = 3'b001;
    bus.d0 = 3'b110;
    e = '{ack: 3'b001, err: 1'b0, data: 3'b110};
    sb_q.push_back(e);
    step();
    chk("cb_wr_d", bus.reg_d, 3'b110);
    bus.clr = 1'b1;
    step();
    wait_ack("cb", 1);
    bus.clr = 1'b0;
    bus.req = 3'b000;
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.clr_done) cnt_a++;
      chk("cb_rst_slot", bus.reg_rst, (i == 1) ? 1 : 0);
    end
    chk("cb_clr_once", cnt_a, 1);
    chk("cb_zero", bus.reg_q, 3'b000);

    // Readback mismatch is flagged on the ack.
    bus.req = 3'b100;
    bus.d2 = 3'b111;
    force_zero = 1'b1;
    e = '{ack: 3'b100, err: 1'b1, data: 3'b000};
    sb_q.push_back(e);
    wait_ack("mm", 3);
    force_zero = 1'b0;
    bus.req = 3'b000;
    step();
    chk("mm_err_off", bus.err, 0);

    // Reset during WRITE aborts without an ack.
    bus.req = 3'b010;
    bus.d1 = 3'b010;
    step();
    chk("ab_ena", bus.reg_ena, 1);
    chk("ab_gnt", bus.gnt, 3'b010);
    er = 1'b1;
    step();
    chk("ab_outputs", {bus.gnt, bus.ack, bus.err, bus.busy, bus.reg_ena, bus.reg_rst,
                       bus.reg_d}, 32'h0);
    er = 1'b0;
    bus.req = 3'b000;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ack != 3'b000) cnt_a++;
      if (bus.busy) cnt_b++;
    end
    chk("ab_no_ack", cnt_a, 0);
    chk("ab_no_busy", cnt_b, 0);

    // Reset also drops a clear that was pending behind a write.
    bus.req = 3'b001;
    bus.d0 = 3'b011;
    step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    er = 1'b1;
    step();
    chk("pd_busy", bus.busy, 0);
    er = 1'b0;
    bus.req = 3'b000;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.clr_done) cnt_a++;
      if (bus.reg_rst) cnt_b++;
      if (bus.ack != 3'b000) cnt_c++;
    end
    chk("pd_no_done", cnt_a, 0);
    chk("pd_no_rst", cnt_b, 0);
    chk("pd_no_ack", cnt_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg2_arbiter.md
Name: reg2_arbiter

Overview:
- Round-robin write arbiter and sequencer that shares one 3-bit register (DFFRSE-based reg2 instance) between three requesters.
- Arbitrates write requests and a clear command, and drives the register's d/enable/reset/set pins.
- Verifies each write by reading the register output back, then acknowledges the requester.
- Sits between requesting control logic and the shared reg2 instance in the datapath.

Parameters:
W, 3, data width of the shared register and of each requester data bus
NREQ, 3, number of requesters (arbitration logic sized for 3; other values not supported)

Ports:
eck  input  1  system clock, all state updates on rising edge
er  input  1  reset, synchronous, active-high
req  input  NREQ  per-requester write request, level, held until ack
d0  input  W  write data of requester 0
d1  input  W  write data of requester 1
d2  input  W  write data of requester 2
clr  input  1  clear command (register to 0), single-cycle pulse or level
reg_q  input  W  readback from shared register sq
reg_d  output  W  data to register ed
reg_ena  output  1  to register eena
reg_rst  output  1  to register er
reg_set  output  1  to register es, tied 0 (reserved)
gnt  output  NREQ  one-hot current owner, 0 when idle
ack  output  NREQ  one-cycle completion pulse to owner
err  output  1  one-cycle pulse with ack when readback mismatched
clr_done  output  1  one-cycle pulse after clear issued
busy  output  1  high in any state except IDLE

Behaviour:
- One clock, eck. Reset is synchronous and active-high, on port er.
- Reset values: state IDLE, rr pointer = requester 0 highest priority, clear-pending flag 0; all outputs 0 (reg_d = 0).
- FSM states: IDLE, WRITE, CHECK, ACK, CLEAR.
- IDLE:
  - Clear-pending or clr = 1 -> CLEAR. Clear has priority over req.
  - Else any req -> WRITE. Winner chosen round-robin starting at pointer. Winner index and its data are latched.
  - Else stay in IDLE.
- WRITE (1 cycle): gnt[w] = 1, reg_d = latched data, reg_ena = 1 -> CHECK.
- CHECK (1 cycle): gnt held, reg_ena = 0. Compare reg_q with latched data; mismatch flag registered -> ACK.
- ACK (1 cycle): ack[w] = 1, err = mismatch flag, pointer := (w+1) mod 3 -> IDLE.
- CLEAR (1 cycle): reg_rst = 1, reg_ena = 0, clear-pending cleared -> IDLE. clr_done pulses in the following IDLE cycle.
- Latency: req sampled in IDLE at cycle t -> reg_ena at t+1 -> compare at t+2 -> ack at t+3 -> IDLE at t+4. Throughput is one write per 4 cycles.
- clr asserted while busy sets clear-pending, so clr is never lost. Multiple clr pulses while busy collapse into a single clear.
- req changes or drops after grant: no effect. The transaction completes on latched data, and ack still pulses.
- Requester must drop req the cycle after ack. If it stays high, it re-arbitrates at lowest priority (pointer has advanced past it).
- Outputs gnt, ack, err, clr_done, reg_* are registered (driven from state/latched values), with no combinational path from req to reg_ena.
- er asserted mid-transaction: next edge returns to IDLE with all outputs 0. No ack is issued for the aborted write, and the pending clear is dropped.

Decomposition:
- Package reg2_arb_pkg holds:
  - state encoding constants (IDLE=3'd0, WRITE=3'd1, CHECK=3'd2, ACK=3'd3, CLEAR=3'd4);
  - REG_W = 3;
  - NREQ = 3.
- Sub-module rr_arb3: combinational round-robin picker.
  - Inputs: req[2:0], pointer[1:0].
  - Outputs: one-hot grant, winner index, any.
  - Instantiated once.
- Shared reg2 stays outside. Bench instantiates it and loops sq back to reg_q.

Test Plan:
- Reset then idle: er = 1 for 2 cycles, req = 000 -> gnt = 000, ack = 000, busy = 0, reg_ena = 0, reg_rst = 0 for 10 cycles.
- Single write: req = 001, d0 = 3'b101 at t -> reg_ena = 1 with reg_d = 101 at t+1; ack = 001, err = 0 at t+3; reg_q = 101 thereafter.
- Round-robin contention: req = 111 held, d0 = 1, d1 = 2, d2 = 3 -> acks in order 001, 010, 100, 001, spaced 4 cycles apart; reg_q follows 1, 2, 3, 1.
- Clear priority: req = 010 and clr = 1 in the same IDLE cycle -> reg_rst = 1 next cycle; clr_done, then requester-1 write starts; reg_q = 000 before the write.
- Clear while busy: clr pulse during CHECK of a write of 3'b110 -> ack for the write first, then CLEAR, then reg_q = 000 and exactly one clr_done.
- Readback mismatch and reset abort: force reg_q = 000 while writing 3'b111 -> ack with err = 1. Assert er during WRITE -> next cycle IDLE, no ack, busy = 0.
